// File: rtl/ras_controller.sv
// ras_controller: return-address stack for the fetch stage.
// Pushes PC+4 on calls, predicts the return target on rets, and exports the
// pre-update tos/cnt as a checkpoint so a mispredict can restore the stack.
// Optional feature macro: RAS_REPAIR_TOP_EN (adds ckpt_top/recover_top so a
// recovery also rewrites the checkpointed top entry).
module ras_controller #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fetch_valid,
  input  logic             is_call,
  input  logic             is_ret,
  input  logic [63:0]      fetch_pc,
  output logic             ret_pred_valid,
  output logic [63:0]      ret_pred_addr,
  output logic [PTR_W-1:0] ckpt_tos,
  output logic [PTR_W:0]   ckpt_cnt,
  input  logic             recover_en,
  input  logic [PTR_W-1:0] recover_tos,
  input  logic [PTR_W:0]   recover_cnt,
`ifdef RAS_REPAIR_TOP_EN
  output logic [63:0]      ckpt_top,
  input  logic [63:0]      recover_top,
`endif
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W-1:0] TOS_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO  = '0;
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

  logic [63:0]      stack [DEPTH];
  logic [PTR_W-1:0] tos;
  logic [PTR_W:0]   cnt;

  logic [63:0]      push_addr;
  logic [PTR_W-1:0] tos_inc;
  logic [PTR_W-1:0] tos_dec;
  logic             has_entries;

  assign push_addr   = fetch_pc + 64'd4;
  assign tos_inc     = tos + TOS_ONE;
  assign tos_dec     = tos - TOS_ONE;
  assign has_entries = (cnt != CNT_ZERO);

  // Zero-latency return prediction from the current top entry.
  always_comb begin
    ret_pred_valid = fetch_valid & is_ret & has_entries;
    ret_pred_addr  = ret_pred_valid ? stack[tos] : 64'd0;
  end

  assign ckpt_tos = tos;
  assign ckpt_cnt = cnt;
  assign empty    = (cnt == CNT_ZERO);
  assign full     = (cnt == CNT_DEPTH);

`ifdef RAS_REPAIR_TOP_EN
  assign ckpt_top = stack[tos];
`endif

  // Stack state update: reset, then recovery (squashes the fetch), then call/ret.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= 64'd0;
      end
      tos <= '0;
      cnt <= '0;
    end else if (recover_en) begin
      tos <= recover_tos;
      cnt <= recover_cnt;
`ifdef RAS_REPAIR_TOP_EN
      if (recover_cnt != CNT_ZERO) begin
        stack[recover_tos] <= recover_top;
      end
`endif
    end else if (fetch_valid) begin
      case ({is_call, is_ret})
        2'b10: begin
          // A push at full wraps over the oldest entry and cnt saturates.
          tos          <= tos_inc;
          stack[tos_inc] <= push_addr;
          if (cnt != CNT_DEPTH) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        2'b01: begin
          if (has_entries) begin
            tos <= tos_dec;
            cnt <= cnt - CNT_ONE;
          end
        end
        2'b11: begin
          // Coroutine call: pop-then-push collapses to replacing the top.
          stack[tos] <= push_addr;
          if (!has_entries) begin
            cnt <= CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
